bram_rmw_engine: RTL and testbench

PL-side read-modify-write engine on the PL port of the shared 8192x32 single-port-style BRAM. The PS fills the buffer, configures the engine and pulses start. The engine then walks a window of words and adds a 32-bit offset to each with unsigned saturation, writing the result back in place. It accumulates a checksum of the original words so the PS can verify what it wrote.

---
 rtl/bram_rmw_engine_if.sv | 29 ++
 rtl/bram_rmw_engine.sv | 153 +++++++++++++++
 tb/tb_bram_rmw_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rmw_engine_if.sv
// Bus bundle between the BRAM read-modify-write engine and its environment:
// PS-side control/status plus the PL port of the shared BRAM.
interface bram_rmw_engine_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W:0]       len;
    logic [DATA_W-1:0]     offset;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     checksum;
    logic [ADDR_W-1:0]     bram_addr;
    logic                  bram_en;
    logic [DATA_W/8-1:0]   bram_we;
    logic [DATA_W-1:0]     bram_din;
    logic [DATA_W-1:0]     bram_dout;

    modport slave (
        input  start, base_addr, len, offset, bram_dout,
        output busy, done, checksum, bram_addr, bram_en, bram_we, bram_din
    );

    modport master (
        output start, base_addr, len, offset, bram_dout,
        input  busy, done, checksum, bram_addr, bram_en, bram_we, bram_din
    );
endinterface

// File: rtl/bram_rmw_engine.sv
// Walks a window of BRAM words, adds a saturating offset to each in place and
// sums the original words into a checksum.
module bram_rmw_engine #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bram_rmw_engine_if.slave bus
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int BE_W  = DATA_W / 8;
    localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    state_t            state_q;
    logic              pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [DATA_W-1:0] offset_q;
    logic [WC_W-1:0]   wait_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] checksum_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic              bram_en_q;
    logic [BE_W-1:0]   bram_we_q;
    logic [DATA_W-1:0] bram_din_q;

    logic [LEN_W-1:0]  len_d;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [LEN_W-1:0]  remain_dec_d;
    logic [DATA_W-1:0] wr_data_d;

    always_comb begin
        len_d        = (bus.len > DEPTH) ? DEPTH : bus.len;
        addr_inc_d   = addr_q + 1'b1;
        remain_dec_d = remain_q - 1'b1;
        wr_data_d    = sat_add(bus.bram_dout, offset_q);
    end

    // An accepted start spends one cycle in IDLE with pend_q set, so busy and the
    // first read appear the cycle after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            offset_q    <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
            bram_addr_q <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_din_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (remain_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_RD;
                            bram_en_q   <= 1'b1;
                            bram_we_q   <= '0;
                            bram_addr_q <= addr_q;
                        end
                    end else if (bus.start) begin
                        pend_q     <= 1'b1;
                        addr_q     <= bus.base_addr;
                        remain_q   <= len_d;
                        offset_q   <= bus.offset;
                        checksum_q <= '0;
                    end
                end
                ST_RD: begin
                    bram_en_q <= 1'b0;
                    wait_q    <= WC_W'(RD_LAT - 1);
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        checksum_q  <= checksum_q + bus.bram_dout;
                        bram_din_q  <= wr_data_d;
                        bram_en_q   <= 1'b1;
                        bram_we_q   <= '1;
                        bram_addr_q <= addr_q;
                        state_q     <= ST_WR;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                ST_WR: begin
                    bram_we_q <= '0;
                    addr_q    <= addr_inc_d;
                    remain_q  <= remain_dec_d;
                    if (remain_dec_d != '0) begin
                        state_q     <= ST_RD;
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= addr_inc_d;
                    end else begin
                        state_q   <= ST_DONE;
                        bram_en_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bram_en_q <= 1'b0;
                    bram_we_q <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.checksum  = checksum_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_en   = bram_en_q;
    assign bus.bram_we   = bram_we_q;
    assign bus.bram_din  = bram_din_q;
endmodule

// File: tb/tb_bram_rmw_engine.sv
// Directed bench for bram_rmw_engine: BRAM model, per-cycle schedule model of
// the engine's outputs, and literal expectations for each scenario.
module tb_bram_rmw_engine;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DEPTH  = 8192;
    localparam int P      = 2 + RD_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bram_rmw_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_rmw_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // BRAM model with activity bookkeeping
    logic [31:0] mem     [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] orig    [DEPTH];
    logic [31:0] rd_pipe [RD_LAT];
    int          wcount  [DEPTH];
    int          wr_total;
    int          rd_addrs[$];

    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (bus.bram_we != '0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] = bus.bram_din[8*b +: 8];
                wcount[bus.bram_addr] = wcount[bus.bram_addr] + 1;
                wr_total = wr_total + 1;
            end else begin
                rd_pipe[0] <= mem[bus.bram_addr];
                rd_addrs.push_back(int'(bus.bram_addr));
            end
        end
        for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign bus.bram_dout = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          run_valid = 1'b0;
    int          run_e0, run_n, run_base;
    logic [31:0] run_off, exp_cks;
    logic [31:0] cks_hold = 32'd0;
    int          done_k, done_cnt, busy_cnt;

    function automatic logic [31:0] sat(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs come from the position k inside the run: word k/P, phase k%P.
    int          k, wi, ph;
    logic        e_busy, e_done, e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_din;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_en", bus.bram_en, 0);
            chk("rst_we", bus.bram_we, 0);
            chk("rst_checksum", bus.checksum, 0);
            chk("rst_addr", bus.bram_addr, 0);
            chk("rst_din", bus.bram_din, 0);
        end else if (!run_valid) begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_en", bus.bram_en, 0);
            chk("idle_we", bus.bram_we, 0);
            chk("idle_checksum", bus.checksum, cks_hold);
        end else begin
            k      = cyc - run_e0;
            e_busy = (k >= 1) && (k <= P*run_n + 1);
            e_done = (k == P*run_n + 1);
            e_en   = 1'b0;
            e_we   = 4'h0;
            e_addr = 32'd0;
            e_din  = 32'd0;
            if (k >= 1 && k <= P*run_n) begin
                wi     = (k - 1) / P;
                ph     = (k - 1) % P;
                e_addr = 32'((run_base + wi) % DEPTH);
                if (ph == 0) begin
                    e_en = 1'b1;
                end else if (ph == P - 1) begin
                    e_en  = 1'b1;
                    e_we  = 4'hF;
                    e_din = sat(orig[wi], run_off);
                end
            end
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            chk("bram_en", bus.bram_en, e_en);
            chk("bram_we", bus.bram_we, e_we);
            if (e_en) chk("bram_addr", bus.bram_addr, e_addr);
            if (e_we != 4'h0) chk("bram_din", bus.bram_din, e_din);
            if (k >= P*run_n + 1) chk("checksum", bus.checksum, exp_cks);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) done_k = k;
            end
        end
    end

    task automatic launch(input int base, input int len, input logic [31:0] off);
        int n, a;
        logic [31:0] cks;
        n   = (len > DEPTH) ? DEPTH : len;
        cks = 32'd0;
        for (int j = 0; j < DEPTH; j++) begin
            exp_mem[j] = mem[j];
            wcount[j]  = 0;
        end
        for (int j = 0; j < n; j++) begin
            a          = (base + j) % DEPTH;
            orig[j]    = mem[a];
            cks        = cks + mem[a];
            exp_mem[a] = sat(mem[a], off);
        end
        wr_total = 0;
        rd_addrs.delete();
        done_cnt = 0;
        busy_cnt = 0;
        done_k   = -1;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(base);
        bus.len       = LEN_W'(len);
        bus.offset    = off;
        @(posedge clk); #1;
        bus.start = 1'b0;
        run_e0    = cyc;
        run_n     = n;
        run_base  = base;
        run_off   = off;
        exp_cks   = cks;
        run_valid = 1'b1;
    endtask

    task automatic check_image();
        int nd;
        nd = 0;
        for (int j = 0; j < DEPTH; j++) if (mem[j] !== exp_mem[j]) nd++;
        chk("mem_image_diffs", nd, 0);
    endtask

    // mid_k > 0 pulses a conflicting start in that cycle of the run.
    task automatic run(input int base, input int len, input logic [31:0] off, input int mid_k);
        launch(base, len, off);
        for (int c = 1; c <= P*run_n + 3; c++) begin
            @(posedge clk); #1;
            bus.start = (c == mid_k);
            if (c == mid_k) begin
                bus.base_addr = 13'h300;
                bus.len       = 14'd2;
                bus.offset    = 32'h7;
            end
        end
        check_image();
    endtask

    logic [31:0] keep;
    int          bad_addrs;

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.offset    = '0;
        for (int j = 0; j < DEPTH; j++) mem[j] = 32'hA500_0000 | 32'(j);
        for (int j = 0; j < RD_LAT; j++) rd_pipe[j] = 32'd0;
        wr_total = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_en", bus.bram_en, 0);
        chk("reset_checksum", bus.checksum, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic four-word window
        for (int j = 0; j < 4; j++) mem[16 + j] = 32'(j + 1);
        run(16, 4, 32'h100, 0);
        for (int j = 0; j < 4; j++) chk("basic_word", mem[16 + j], 32'h101 + 32'(j));
        chk("basic_checksum", bus.checksum, 32'd10);
        chk("basic_done_k", done_k, 13);
        chk("basic_busy_cycles", busy_cnt, 13);
        chk("basic_done_count", done_cnt, 1);

        // Saturation
        mem[32] = 32'hFFFF_FFF0;
        run(32, 1, 32'h20, 0);
        chk("sat_word", mem[32], 32'hFFFF_FFFF);
        chk("sat_checksum", bus.checksum, 32'hFFFF_FFF0);
        chk("sat_done_k", done_k, 4);

        // Address wrap 8191 -> 0
        mem[8190] = 32'h1111_1111;
        mem[8191] = 32'h2222_2222;
        mem[0]    = 32'h3333_3333;
        mem[1]    = 32'hFFFF_FFFE;
        keep      = mem[2];
        run(8190, 4, 32'h5, 0);
        chk("wrap_w0", mem[8190], 32'h1111_1116);
        chk("wrap_w1", mem[8191], 32'h2222_2227);
        chk("wrap_w2", mem[0], 32'h3333_3338);
        chk("wrap_w3", mem[1], 32'hFFFF_FFFF);
        chk("wrap_untouched", mem[2], keep);
        chk("wrap_checksum", bus.checksum, 32'h6666_6664);
        chk("wrap_rd_count", rd_addrs.size(), 4);
        if (rd_addrs.size() == 4) begin
            chk("wrap_addr0", rd_addrs[0], 8190);
            chk("wrap_addr1", rd_addrs[1], 8191);
            chk("wrap_addr2", rd_addrs[2], 0);
            chk("wrap_addr3", rd_addrs[3], 1);
        end

        // Zero length
        run(64, 0, 32'h55, 0);
        chk("zero_done_k", done_k, 1);
        chk("zero_checksum", bus.checksum, 0);
        chk("zero_bram_accesses", wr_total + rd_addrs.size(), 0);

        // Over-length clamps to the full buffer
        run(32'h1234, 16383, 32'h1, 0);
        chk("full_writes", wr_total, 8192);
        bad_addrs = 0;
        for (int j = 0; j < DEPTH; j++) if (wcount[j] != 1) bad_addrs++;
        chk("full_once_per_addr", bad_addrs, 0);
        chk("full_done_k", done_k, 3*8192 + 1);

        // Start during a run is ignored
        mem[128] = 32'd10; mem[129] = 32'd20; mem[130] = 32'd30; mem[131] = 32'd40;
        keep = mem[32'h300];
        run(128, 4, 32'h1000, 5);
        chk("mid_w0", mem[128], 32'h100A);
        chk("mid_w3", mem[131], 32'h1028);
        chk("mid_other_base", mem[32'h300], keep);
        chk("mid_checksum", bus.checksum, 32'd100);
        chk("mid_done_count", done_cnt, 1);

        // Reset during the third word's WAIT
        mem[144] = 32'h111; mem[145] = 32'h222; mem[146] = 32'h333; mem[147] = 32'h444;
        launch(144, 4, 32'h10);
        repeat (8) begin
            @(posedge clk); #1;
        end
        #1;
        rst_n     = 1'b0;
        run_valid = 1'b0;
        cks_hold  = 32'd0;
        #1;
        chk("abort_en_now", bus.bram_en, 0);
        chk("abort_we_now", bus.bram_we, 0);
        chk("abort_busy_now", bus.busy, 0);
        chk("abort_checksum_now", bus.checksum, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_w0", mem[144], 32'h121);
        chk("abort_w1", mem[145], 32'h232);
        chk("abort_w2", mem[146], 32'h333);
        chk("abort_w3", mem[147], 32'h444);
        chk("abort_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
